// File: rtl/cpu32_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu32_mem_pkg
// Brief   : Shared types and defaults for the CPU32 memory arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package cpu32_mem_pkg;

    localparam int c_DEF_ADDR_W = 32;
    localparam int c_DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin pick with the last-grant history register.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
    import cpu32_mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    fetch_req,
    input  logic    data_req,
    input  logic    take,
    output logic    valid,
    output req_id_t pick
);

    req_id_t r_last;

    always_comb begin
        valid = fetch_req | data_req;
        pick  = FETCH;
        if (fetch_req && data_req) begin
            pick = (r_last == FETCH) ? DATA : FETCH;
        end else if (data_req) begin
            pick = DATA;
        end
    end

    // Starting from DATA hands the very first tie to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= DATA;
        end else if (take && valid) begin
            r_last <= pick;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one single-ported word RAM between fetch and load/store.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu32_mem_pkg::*;
#(
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_ack,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [ADDR_W-1:0] m_r_addr,
    output logic [ADDR_W-1:0] m_w_addr,
    output logic [DATA_W-1:0] m_w_line,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_r_line,
    input  logic              m_rrdy,
    input  logic              m_wrdy,
    input  logic              m_exc
);

    localparam int                 c_CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

    arb_state_t         r_state;
    req_id_t            r_gnt;
    logic [c_CNT_W-1:0] r_cnt;

    logic    w_valid;
    req_id_t w_pick;
    logic    w_take;
    logic    w_resp_ok;
    logic    w_abort;

    assign w_take    = (r_state == ST_IDLE);
    // RAM status is registered one edge after the strobe, so cnt==0 sees stale flags.
    assign w_resp_ok = (r_cnt != '0);
    assign w_abort   = (w_resp_ok && m_exc) || (r_cnt == c_TIMEOUT_CNT);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (if_req),
        .data_req  (d_req),
        .take      (w_take),
        .valid     (w_valid),
        .pick      (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= FETCH;
            r_cnt    <= '0;
            if_data  <= '0;
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            d_rdata  <= '0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            m_r_addr <= '0;
            m_w_addr <= '0;
            m_w_line <= '0;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt <= w_pick;
                        r_cnt <= '0;
                        if (w_pick == FETCH) begin
                            m_r_addr <= if_addr;
                            m_read   <= 1'b1;
                            r_state  <= ST_RD;
                        end else if (d_we) begin
                            m_w_addr <= d_addr;
                            m_w_line <= d_wdata;
                            m_write  <= 1'b1;
                            r_state  <= ST_WR;
                        end else begin
                            m_r_addr <= d_addr;
                            m_read   <= 1'b1;
                            r_state  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_resp_ok && m_rrdy) begin
                        m_read  <= 1'b0;
                        r_state <= ST_DONE;
                        if (r_gnt == FETCH) begin
                            if_data <= m_r_line;
                            if_ack  <= 1'b1;
                        end else begin
                            d_rdata <= m_r_line;
                            d_ack   <= 1'b1;
                        end
                    end else if (w_abort) begin
                        m_read  <= 1'b0;
                        r_state <= ST_DONE;
                        if (r_gnt == FETCH) begin
                            if_err <= 1'b1;
                        end else begin
                            d_err <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_resp_ok && m_wrdy) begin
                        m_write <= 1'b0;
                        d_ack   <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_abort) begin
                        m_write <= 1'b0;
                        d_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Turnaround cycle: RAM drops rrdy/wrdy, requests are not sampled.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter with a 1024-word RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ack, if_err;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack, d_err;
    logic [31:0] m_r_addr, m_w_addr, m_w_line, m_r_line;
    logic        m_read, m_write, m_rrdy, m_wrdy, m_exc;

    logic [31:0] mem [0:1023];
    logic        ram_rrdy, ram_wrdy, ram_exc;
    logic        stall;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int wr_rise_cyc = 0;
    int rd_rise_cyc = 0;
    bit prev_read = 1'b0;
    bit prev_write = 1'b0;
    bit write_seen = 1'b0;
    bit both_hi = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
        .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_r_addr(m_r_addr), .m_w_addr(m_w_addr), .m_w_line(m_w_line),
        .m_read(m_read), .m_write(m_write), .m_r_line(m_r_line),
        .m_rrdy(m_rrdy), .m_wrdy(m_wrdy), .m_exc(m_exc)
    );

    // RAM model: registered responses, sticky exc until reset.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst) begin
            ram_rrdy <= 1'b0;
            ram_wrdy <= 1'b0;
            ram_exc  <= 1'b0;
            m_r_line <= '0;
        end else begin
            ram_rrdy <= 1'b0;
            ram_wrdy <= 1'b0;
            if (m_read) begin
                if (m_r_addr < 32'd1024) begin
                    m_r_line <= mem[m_r_addr[9:0]];
                    ram_rrdy <= 1'b1;
                end else begin
                    ram_exc <= 1'b1;
                end
            end
            if (m_write) begin
                if (m_w_addr < 32'd1024) begin
                    mem[m_w_addr[9:0]] <= m_w_line;
                    ram_wrdy <= 1'b1;
                end else begin
                    ram_exc <= 1'b1;
                end
            end
        end
    end

    assign m_rrdy = stall ? 1'b0 : ram_rrdy;
    assign m_wrdy = stall ? 1'b0 : ram_wrdy;
    assign m_exc  = stall ? 1'b0 : ram_exc;

    always @(negedge clk) begin
        if (m_read && !prev_read)   rd_rise_cyc = cyc_cnt;
        if (m_write && !prev_write) wr_rise_cyc = cyc_cnt;
        if (m_write)                write_seen = 1'b1;
        if (m_read && m_write)      both_hi = 1'b1;
        prev_read  = m_read;
        prev_write = m_write;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input bit is_data, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int n, output bit ack, output bit err);
        if (is_data) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0; ack = 1'b0; err = 1'b0;
        while (n < 40 && !ack && !err) begin
            tick();
            n++;
            ack = is_data ? d_ack : if_ack;
            err = is_data ? d_err : if_err;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        int n;
        bit ack, err;
        int ack_id [4];
        int ack_tk [4];
        int na;
        bit dual;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h0000_1111;
        mem[1] = 32'hAAAA_0001;
        mem[2] = 32'hBBBB_0002;
        mem[3] = 32'h3333_3333;
        mem[5] = 32'hDEAD_BEEF;
        mem[7] = 32'hCAFE_0007;
        rst = 1'b1; stall = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        tick(); tick();
        check("rst_if_ack", if_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_write", m_write, 1'b0);
        rst = 1'b0;
        tick();

        // Fetch read
        write_seen = 1'b0;
        run_xfer(1'b0, 1'b0, 32'd5, 32'd0, n, ack, err);
        check("fetch_lat", n, 3);
        check("fetch_ack", ack, 1'b1);
        check("fetch_data", if_data, 32'hDEAD_BEEF);
        check("fetch_no_write", write_seen, 1'b0);
        tick();
        check("fetch_ack_pulse", if_ack, 1'b0);
        tick();

        // Data write then read back
        run_xfer(1'b1, 1'b1, 32'd10, 32'h1234_5678, n, ack, err);
        check("wr_ack", ack, 1'b1);
        check("wr_lat", n, 3);
        run_xfer(1'b1, 1'b0, 32'd10, 32'd0, n, ack, err);
        check("rd_ack", ack, 1'b1);
        check("rd_data", d_rdata, 32'h1234_5678);
        check("wr_rd_spacing", (rd_rise_cyc - wr_rise_cyc) >= 4, 1'b1);
        tick(); tick();

        // Out-of-range read
        run_xfer(1'b1, 1'b0, 32'd2000, 32'd0, n, ack, err);
        check("oor_err", err, 1'b1);
        check("oor_ack", d_ack, 1'b0);
        check("oor_lat", n, 3);
        check("oor_rdata_kept", d_rdata, 32'h1234_5678);
        tick();
        check("oor_err_pulse", d_err, 1'b0);
        tick();
        run_xfer(1'b1, 1'b0, 32'd0, 32'd0, n, ack, err);
        check("stale_exc_ack", ack, 1'b1);
        check("stale_exc_err", err, 1'b0);
        check("stale_exc_data", d_rdata, 32'h0000_1111);
        tick(); tick();

        // Stalled RAM, timeout
        stall = 1'b1;
        run_xfer(1'b0, 1'b0, 32'd3, 32'd0, n, ack, err);
        check("to_err", err, 1'b1);
        check("to_ack", ack, 1'b0);
        check("to_lat", n, 17);
        check("to_read_low", m_read, 1'b0);
        check("to_data_kept", if_data, 32'hDEAD_BEEF);
        stall = 1'b0;
        tick(); tick();

        // Tie from reset, both held: alternation
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
        tick(); tick();
        rst = 1'b0;
        na = 0; dual = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (if_ack && d_ack) dual = 1'b1;
            if (na < 4 && if_ack) begin ack_id[na] = 0; ack_tk[na] = t; na++; end
            else if (na < 4 && d_ack) begin ack_id[na] = 1; ack_tk[na] = t; na++; end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("rr_count", na, 4);
        check("rr_first_fetch", ack_id[0], 0);
        check("rr_second_data", ack_id[1], 1);
        check("rr_third_fetch", ack_id[2], 0);
        check("rr_fourth_data", ack_id[3], 1);
        check("rr_first_tick", ack_tk[0], 3);
        check("rr_second_tick", ack_tk[1], 7);
        check("rr_no_dual", dual, 1'b0);
        check("rr_if_data", if_data, 32'hAAAA_0001);
        check("rr_d_rdata", d_rdata, 32'hBBBB_0002);
        tick(); tick();

        // Reset while in RD
        if_req = 1'b1; if_addr = 32'd7;
        tick();
        check("mid_read_hi", m_read, 1'b1);
        rst = 1'b1; if_req = 1'b0;
        tick();
        check("mrst_read", m_read, 1'b0);
        check("mrst_write", m_write, 1'b0);
        check("mrst_if_ack", if_ack, 1'b0);
        check("mrst_if_err", if_err, 1'b0);
        check("mrst_if_data", if_data, 32'h0);
        check("mrst_d_rdata", d_rdata, 32'h0);
        check("mrst_r_addr", m_r_addr, 32'h0);
        rst = 1'b0;
        tick();
        check("mrst_no_ack", if_ack, 1'b0);
        run_xfer(1'b0, 1'b0, 32'd7, 32'd0, n, ack, err);
        check("post_rst_ack", ack, 1'b1);
        check("post_rst_lat", n, 3);
        check("post_rst_data", if_data, 32'hCAFE_0007);
        tick(); tick();

        check("never_both_strobes", both_hi, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-ported word RAM (`ram`, rrdy/wrdy handshake variant) between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sits between the CPU32 core front-end and `ram`.
- Owns all RAM strobes and enforces the RAM's one-cycle turnaround.
- Converts RAM ready/exception into per-requester ack/err pulses, with a timeout guard.

Parameters:
- ADDR_W, 32, word-address width passed unchanged to RAM
- DATA_W, 32, data word width
- TIMEOUT, 15, wait cycles before a transfer is aborted with err (min 2)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch read request, held until if_ack/if_err
- if_addr  in  ADDR_W  fetch word address
- if_data  out  DATA_W  fetch read data, valid with if_ack
- if_ack  out  1  one-cycle completion pulse
- if_err  out  1  one-cycle error pulse (RAM exc or timeout)
- d_req  in  1  data request, held until d_ack/d_err
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid with d_ack on a read
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  one-cycle error pulse
- m_r_addr  out  ADDR_W  to RAM r_addr
- m_w_addr  out  ADDR_W  to RAM w_addr
- m_w_line  out  DATA_W  to RAM w_line
- m_read  out  1  to RAM read
- m_write  out  1  to RAM write
- m_r_line  in  DATA_W  from RAM r_line
- m_rrdy  in  1  from RAM rrdy
- m_wrdy  in  1  from RAM wrdy
- m_exc  in  1  from RAM exc

Behaviour:
- Reset values:
  - All outputs registered; 0 on rst.
  - State IDLE; cnt = 0; last_grant = DATA, so the first tie goes to FETCH.
- States:
  - IDLE: sample requests.
    - None → stay.
    - One → grant it.
    - Both → grant the requester not in last_grant (round-robin), then update last_grant.
    - Grant FETCH or data read → RD. Data write → WR.
    - On grant: latch addr/wdata into the m_* registers, set m_read or m_write, clear cnt.
  - RD/WR: hold the m_* outputs stable; cnt increments each cycle.
    - Completion is recognised only when cnt ≥ 1, because the RAM response is registered one edge after the strobe.
    - RD success: m_rrdy = 1. Capture m_r_line into if_data/d_rdata, drop m_read, go to DONE with ack.
    - WR success: m_wrdy = 1. Drop m_write, go to DONE with ack.
    - Error: m_exc = 1 with rdy low, or cnt == TIMEOUT. Drop strobes, go to DONE with err. Read-data output is unchanged.
  - DONE: exactly one cycle.
    - Assert ack or err for the granted requester only.
    - Strobes stay low; this cycle lets the RAM clear rrdy/wrdy.
    - Requests are ignored in this cycle; go to IDLE.
- Latency: a request is seen at edge k; the strobe is visible after k; the RAM responds at k+1; the arbiter registers completion at k+2.
  - Ack is high in the cycle after edge k+2.
  - Minimum 4-cycle request-to-request spacing per requester.
- Requester rules:
  - The requester must drop req (or present a new transaction) in the cycle after ack/err.
  - req still high in IDLE is a new transaction.
- m_exc is sticky in the RAM between operations and is evaluated only in RD/WR with cnt ≥ 1.
- Only one of m_read/m_write is ever high; both are low in IDLE and DONE.
- Reset mid-operation:
  - Return to IDLE with all strobes low; no ack/err is issued.
  - A write already sampled by the RAM may still complete; requesters must reissue.
- Address range checking is left to the RAM; no address translation.

Decomposition:
- Shared package cpu32_mem_pkg:
  - state encoding (IDLE, RD, WR, DONE)
  - requester IDs (FETCH = 0, DATA = 1)
  - default ADDR_W/DATA_W
- One sub-module `rr_arb2`: combinational 2-way round-robin pick, plus the last_grant register update.

Test Plan:
- Fetch read, mem[5] = 32'hDEADBEEF, if_req at cycle 0 → if_ack high in cycle 3, if_data = 32'hDEADBEEF, m_write never high.
- Data write d_addr = 10, d_wdata = 32'h12345678, then data read addr 10 → d_ack on both, d_rdata = 32'h12345678, second m_read rises no earlier than 4 cycles after the first m_write.
- if_req and d_req both high from reset → FETCH served first, DATA second; repeat with both held → grants alternate.
- Read d_addr = 2000 with mem_size 1024 → d_err one cycle, d_ack stays 0; next valid read to addr 0 completes with ack despite stale m_exc.
- RAM model stalled (rrdy/exc tied low), TIMEOUT = 15 → if_err after 15 wait cycles, m_read low in the DONE cycle.
- rst asserted in RD state → next cycle all outputs 0, state IDLE, no ack pulse; a new request is then served normally.
